// File: rtl/fir_resp_checker_if.sv
// fir_resp_checker_if: golden-sample push port and DUT output stream
interface fir_resp_checker_if #(
  parameter int DATA_WIDTH = 16
);
  logic exp_valid;
  logic exp_ready;
  logic [DATA_WIDTH-1:0] exp_data;
  logic dut_valid;
  logic [DATA_WIDTH-1:0] dut_data;
  modport master(output exp_valid, exp_data, dut_valid, dut_data, input exp_ready);
  modport slave(input exp_valid, exp_data, dut_valid, dut_data, output exp_ready);
endinterface

// File: rtl/fir_resp_checker.sv
// fir_resp_checker: compares a DUT sample stream against an in-order golden FIFO
module fir_resp_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic start,
  input  logic [CNT_WIDTH-1:0] n_samples,
  fir_resp_checker_if.slave bus,
  output logic [CNT_WIDTH-1:0] match_cnt,
  output logic [CNT_WIDTH-1:0] mism_cnt,
  output logic [CNT_WIDTH-1:0] first_idx,
  output logic [DATA_WIDTH-1:0] first_exp,
  output logic [DATA_WIDTH-1:0] first_got,
  output logic underflow,
  output logic overrun,
  output logic timeout,
  output logic done,
  output logic pass,
  output logic fail
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic [CNT_WIDTH-1:0] n_target, idx;
  logic [WW-1:0] wd;
  logic empty, push, pop, arm, last, cmp, hit, wd_exp;
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] x);
    return x + CNT_WIDTH'(x != '1);
  endfunction
  assign empty = count == '0;
  assign bus.exp_ready = count != (AW+1)'(DEPTH);
  assign push = bus.exp_valid && bus.exp_ready && !clear;
  assign arm = start && state != RUN;
  assign last = state == RUN && idx == n_target;
  assign cmp = state == RUN && !last && bus.dut_valid;
  assign pop = cmp && !empty;
  assign hit = pop && bus.dut_data == mem[rptr];
  assign wd_exp = state == RUN && !last && !bus.dut_valid && wd == WW'(TIMEOUT - 1);
  assign done = state == DONE;
  assign fail = done && (mism_cnt != '0 || timeout || overrun);
  assign pass = done && !fail;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: clear beats start, start beats completion
  always_comb begin
    state_nx = clear ? IDLE : arm ? (n_samples == '0 ? DONE : RUN) : (last || wd_exp) ? DONE : state;
  end
  // golden sample storage, no reset needed
  always_ff @(posedge clk)
    if (push) mem[wptr] <= bus.exp_data;
  // FIFO pointers and registered occupancy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // compare counters, sticky flags, first-error capture and watchdog
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      match_cnt <= '0;
      mism_cnt <= '0;
      first_idx <= '0;
      first_exp <= '0;
      first_got <= '0;
      underflow <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
      n_target <= '0;
      idx <= '0;
      wd <= '0;
    end else if (clear || arm) begin
      match_cnt <= '0;
      mism_cnt <= '0;
      first_idx <= '0;
      first_exp <= '0;
      first_got <= '0;
      underflow <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
      n_target <= n_samples;
      idx <= '0;
      wd <= '0;
    end else begin
      if (state == DONE && bus.dut_valid) overrun <= 1'b1;
      if (wd_exp) timeout <= 1'b1;
      wd <= (state != RUN || bus.dut_valid) ? '0 : wd + WW'(1);
      if (cmp) begin
        idx <= sat_inc(idx);
        if (hit) match_cnt <= sat_inc(match_cnt);
        else begin
          mism_cnt <= sat_inc(mism_cnt);
          if (empty) underflow <= 1'b1;
          if (mism_cnt == '0) begin
            first_idx <= idx;
            first_exp <= empty ? '0 : mem[rptr];
            first_got <= bus.dut_data;
          end
        end
      end
    end
endmodule

// File: tb/tb_fir_resp_checker.sv
// tb_fir_resp_checker: randomized directed bench against a queue-based reference model
module tb_fir_resp_checker;
  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam int CW = 16;
  localparam int TO = 1024;
  logic clk = 0, rst = 1, clear = 0, start = 0;
  logic [CW-1:0] n_samples = '0;
  logic [CW-1:0] match_cnt, mism_cnt, first_idx;
  logic [DW-1:0] first_exp, first_got;
  logic underflow, overrun, timeout, done, pass, fail;
  int total = 0, passed = 0, fails = 0;
  fir_resp_checker_if #(.DATA_WIDTH(DW)) bus ();
  fir_resp_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .n_samples(n_samples), .bus(bus),
    .match_cnt(match_cnt), .mism_cnt(mism_cnt), .first_idx(first_idx), .first_exp(first_exp),
    .first_got(first_got), .underflow(underflow), .overrun(overrun), .timeout(timeout),
    .done(done), .pass(pass), .fail(fail)
  );
  always #5 clk = ~clk;
  // reference model: golden queue plus run bookkeeping (0 idle, 1 running, 2 finished)
  logic [DW-1:0] q[$];
  int mst, m_n, m_cmp, m_idle, m_match, m_mism, m_fidx;
  logic [DW-1:0] m_fexp, m_fgot;
  bit m_uf, m_ov, m_to;
  task automatic m_zero();
    m_match = 0; m_mism = 0; m_fidx = 0; m_fexp = '0; m_fgot = '0;
    m_uf = 0; m_ov = 0; m_to = 0; m_cmp = 0; m_idle = 0;
  endtask
  task automatic m_reset();
    m_zero(); q.delete(); mst = 0; m_n = 0;
  endtask
  task automatic model_step(input bit pv, input logic [DW-1:0] pd, input bit dv, input logic [DW-1:0] dd,
                            input bit st, input int n, input bit clr);
    bit acc, ok;
    logic [DW-1:0] e;
    acc = pv && q.size() < DEPTH;
    if (clr) m_reset();
    else begin
      if (st && mst != 1) begin
        m_zero(); m_n = n; mst = (n == 0) ? 2 : 1;
      end else if (mst == 1) begin
        if (m_cmp == m_n) mst = 2;
        else if (dv) begin
          m_idle = 0;
          if (q.size() == 0) begin e = '0; m_uf = 1; ok = 0; end
          else begin e = q.pop_front(); ok = (e == dd); end
          if (ok) m_match++;
          else begin
            if (m_mism == 0) begin m_fidx = m_cmp; m_fexp = e; m_fgot = dd; end
            m_mism++;
          end
          m_cmp++;
        end else begin
          m_idle++;
          if (m_idle == TO) begin m_to = 1; mst = 2; end
        end
      end else if (mst == 2 && dv) m_ov = 1;
      if (acc) q.push_back(pd);
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string t);
    bit d, f;
    d = (mst == 2);
    f = d && (m_mism != 0 || m_to || m_ov);
    chk({t, ".exp_ready"}, 32'(bus.exp_ready), 32'(q.size() < DEPTH));
    chk({t, ".match_cnt"}, 32'(match_cnt), 32'(m_match));
    chk({t, ".mism_cnt"}, 32'(mism_cnt), 32'(m_mism));
    chk({t, ".first_idx"}, 32'(first_idx), 32'(m_fidx));
    chk({t, ".first_exp"}, 32'(first_exp), 32'(m_fexp));
    chk({t, ".first_got"}, 32'(first_got), 32'(m_fgot));
    chk({t, ".underflow"}, 32'(underflow), 32'(m_uf));
    chk({t, ".overrun"}, 32'(overrun), 32'(m_ov));
    chk({t, ".timeout"}, 32'(timeout), 32'(m_to));
    chk({t, ".done"}, 32'(done), 32'(d));
    chk({t, ".pass"}, 32'(pass), 32'(d && !f));
    chk({t, ".fail"}, 32'(fail), 32'(f));
  endtask
  // one clock: drive at the falling edge, model the rising edge, return at the next falling edge
  task automatic cyc(input bit pv, input logic [DW-1:0] pd, input bit dv, input logic [DW-1:0] dd,
                     input bit st, input int n, input bit clr);
    bus.exp_valid = pv; bus.exp_data = pd; bus.dut_valid = dv; bus.dut_data = dd;
    start = st; n_samples = CW'(n); clear = clr;
    @(posedge clk);
    model_step(pv, pd, dv, dd, st, n, clr);
    @(negedge clk);
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, '0, 0, '0, 0, 0, 0);
  endtask
  task automatic push(input logic [DW-1:0] d); cyc(1, d, 0, '0, 0, 0, 0); endtask
  task automatic sample(input logic [DW-1:0] d); cyc(0, '0, 1, d, 0, 0, 0); endtask
  task automatic go(input int n); cyc(0, '0, 0, '0, 1, n, 0); endtask
  task automatic clr(); cyc(0, '0, 0, '0, 0, 0, 1); endtask
  function automatic logic [DW-1:0] rnd(); return DW'($urandom); endfunction
  initial begin
    bit pv, dv;
    logic [DW-1:0] dd;
    int n;
    bus.exp_valid = 0; bus.exp_data = '0; bus.dut_valid = 0; bus.dut_data = '0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    check_all("reset");
    for (int i = 1; i <= 8; i++) push(DW'(i));
    go(8);
    for (int i = 1; i <= 7; i++) begin sample(DW'(i)); idle($urandom_range(0, 2)); end
    sample(DW'(8));
    check_all("lat_cnt");
    chk("lat_cnt.done_low", 32'(done), 0);
    idle(1);
    check_all("match8");
    chk("match8.pass", 32'(pass), 1);
    clr();
    for (int i = 1; i <= 8; i++) push(DW'(i));
    go(8);
    for (int i = 0; i < 8; i++) sample(i == 3 ? 16'h00FF : DW'(i + 1));
    idle(1);
    check_all("mism1");
    chk("mism1.first_idx", 32'(first_idx), 3);
    chk("mism1.first_exp", 32'(first_exp), 32'h4);
    chk("mism1.first_got", 32'(first_got), 32'hFF);
    chk("mism1.fail", 32'(fail), 1);
    clr();
    sample(16'h1234);
    check_all("idle_dv");
    go(0);
    check_all("n0");
    chk("n0.pass", 32'(pass), 1);
    clr();
    go(4);
    sample(rnd());
    check_all("uflow");
    chk("uflow.underflow", 32'(underflow), 1);
    for (int i = 0; i < 16; i++) push(rnd());
    check_all("full");
    chk("full.exp_ready", 32'(bus.exp_ready), 0);
    cyc(1, rnd(), 1, q[0], 0, 0, 0);
    check_all("push_pop");
    chk("push_pop.exp_ready", 32'(bus.exp_ready), 1);
    push(rnd());
    check_all("refill");
    chk("refill.exp_ready", 32'(bus.exp_ready), 0);
    sample(q[0]);
    sample(rnd());
    idle(1);
    check_all("t4_end");
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) clr();
      n = $urandom_range(1, 12);
      for (int k = $urandom_range(0, 6); k > 0; k--) push(rnd());
      go(n);
      for (int c = 0; c < 400 && mst != 2; c++) begin
        pv = 1'($urandom % 2);
        dv = 1'($urandom % 2);
        dd = (q.size() > 0 && $urandom % 8 != 0) ? q[0] : rnd();
        cyc(pv, rnd(), dv, dd, 0, 0, 0);
      end
      repeat (3) cyc(0, '0, 1'($urandom % 4 == 0), rnd(), 0, 0, 0);
      check_all($sformatf("rand%0d", r));
    end
    clr();
    push(rnd());
    push(rnd());
    go(2);
    sample(q[0]);
    idle(1000);
    check_all("wd_pre");
    idle(30);
    check_all("wd_post");
    chk("wd.timeout", 32'(timeout), 1);
    chk("wd.fail", 32'(fail), 1);
    clr();
    for (int i = 0; i < 5; i++) push(rnd());
    go(8);
    idle(3);
    #2 rst = 1;
    m_reset();
    #1 check_all("async_rst");
    chk("async_rst.exp_ready", 32'(bus.exp_ready), 1);
    @(negedge clk);
    rst = 0;
    idle(1);
    check_all("post_rst");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
